// File: rtl/mnist_pkg.sv
// Shared types and width helpers for the MNIST neuron datapath.
package mnist_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} mac_state_t;

   function automatic int acc_width(input int bits);
      return bits + 25;
   endfunction

   localparam int DEFAULT_BITS = 8;
   localparam int ACC_W = acc_width(DEFAULT_BITS);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/neuron_mac_if.sv
// Handshake and result bundle between the layer controller/feeder and one neuron_mac.
interface neuron_mac_if
   import mnist_pkg::*;
#(
   parameter int BITS   = 8,
   parameter int W_BITS = 8
) ();

   logic                              start;
   logic                              in_valid;
   logic                              in_ready;
   logic signed [BITS+8:0]            data_in;
   logic signed [W_BITS:0]            weight_in;
   logic [31:0]                       counter;
   logic signed [acc_width(BITS)-1:0] mult_sum_out;
   logic                              done;

   modport master (
      output start, in_valid, data_in, weight_in,
      input  in_ready, counter, mult_sum_out, done
   );

   modport slave (
      input  start, in_valid, data_in, weight_in,
      output in_ready, counter, mult_sum_out, done
   );

endinterface

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the representable range instead of wrapping.
module sat_add #(
   parameter int W = 33
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);

   localparam logic signed [W-1:0] HI = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] LO = {1'b1, {(W-1){1'b0}}};

   logic signed [W:0] full;

   always_comb begin
      full = {a[W-1], a} + {b[W-1], b};
      y    = full[W-1:0];
      // Guard bit disagreeing with the result sign means the true sum left the range.
      if (full[W] != full[W-1]) begin
         y = full[W] ? LO : HI;
      end
   end

endmodule

// File: rtl/neuron_mac.sv
// Streaming saturating dot-product for one neuron: input register, product register,
// then accumulate; `done` marks the final sum for the layer controller.
module neuron_mac
   import mnist_pkg::*;
#(
   parameter int BITS        = 8,
   parameter int COUNTER_END = 784,
   parameter int W_BITS      = 8
) (
   input logic         clk,
   input logic         rst_n,
   neuron_mac_if.slave bus
);

   localparam int SUM_W  = acc_width(BITS);
   localparam int PROD_W = BITS + W_BITS + 10;
   localparam logic [31:0] TERMS      = 32'(COUNTER_END);
   localparam logic [31:0] TERMS_LAST = 32'(COUNTER_END - 1);

   mac_state_t state, state_nxt;

   logic [31:0]              issued;
   logic [31:0]              counter;
   logic signed [SUM_W-1:0]  sum;
   logic signed [SUM_W-1:0]  sum_nxt;
   logic signed [SUM_W-1:0]  prod_ext;
   logic signed [BITS+8:0]   data_q;
   logic signed [W_BITS:0]   weight_q;
   logic signed [PROD_W-1:0] prod_q;
   logic                     v1;
   logic                     v2;
   logic                     ready;
   logic                     accept;
   logic                     clear;

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      clear     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               clear     = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            ready = (issued < TERMS);
            if (bus.in_valid && ready && (issued == TERMS_LAST)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Leave in the same edge the last product lands, so done aligns with counter.
            if (v2 && (counter == TERMS_LAST)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               clear     = 1'b1;
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = IDLE;
      endcase
      accept = bus.in_valid && ready;
   end

   assign prod_ext = {{(SUM_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

   sat_add #(.W(SUM_W)) u_sat_add (
      .a (sum),
      .b (prod_ext),
      .y (sum_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         issued   <= '0;
         counter  <= '0;
         sum      <= '0;
         data_q   <= '0;
         weight_q <= '0;
         prod_q   <= '0;
         v1       <= 1'b0;
         v2       <= 1'b0;
      end else begin
         state <= state_nxt;
         v1    <= accept;
         v2    <= v1;
         if (accept) begin
            data_q   <= bus.data_in;
            weight_q <= bus.weight_in;
         end
         if (v1) begin
            prod_q <= PROD_W'(data_q) * PROD_W'(weight_q);
         end
         if (clear) begin
            issued  <= '0;
            counter <= '0;
            sum     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
         end else begin
            if (accept) begin
               issued <= issued + 32'd1;
            end
            if (v2) begin
               counter <= counter + 32'd1;
               sum     <= sum_nxt;
            end
         end
      end
   end

   assign bus.in_ready     = ready;
   assign bus.counter      = counter;
   assign bus.mult_sum_out = sum;
   assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: 784-term run, stalled short run, saturation, reset and start corners.
module tb_neuron_mac;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;

   always #5 clk = ~clk;

   neuron_mac_if #(.BITS(8), .W_BITS(8))  ia ();
   neuron_mac_if #(.BITS(8), .W_BITS(8))  ib ();
   neuron_mac_if #(.BITS(8), .W_BITS(14)) ic ();

   neuron_mac #(.BITS(8), .COUNTER_END(784), .W_BITS(8))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   neuron_mac #(.BITS(8), .COUNTER_END(4),   .W_BITS(8))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
   neuron_mac #(.BITS(8), .COUNTER_END(6),   .W_BITS(14)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

   typedef struct {
      logic v;
      int   d;
      int   w;
      int   ec;
      int   es;
      logic ed;
      logic er;
   } vec_t;

   vec_t tv[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      int cyc;

      // per-cycle vectors for the COUNTER_END=4 instance with in_valid toggling
      tv[0] = '{1'b1,  3, -2, 0,   0, 1'b0, 1'b1};
      tv[1] = '{1'b0,  0,  0, 0,   0, 1'b0, 1'b1};
      tv[2] = '{1'b1, -5,  4, 1,  -6, 1'b0, 1'b1};
      tv[3] = '{1'b0,  0,  0, 1,  -6, 1'b0, 1'b1};
      tv[4] = '{1'b1,  7,  7, 2, -26, 1'b0, 1'b1};
      tv[5] = '{1'b0,  0,  0, 2, -26, 1'b0, 1'b1};
      tv[6] = '{1'b1, -1, -1, 3,  23, 1'b0, 1'b0};
      tv[7] = '{1'b0,  0,  0, 3,  23, 1'b0, 1'b0};
      tv[8] = '{1'b0,  0,  0, 4,  24, 1'b1, 1'b0};
      tv[9] = '{1'b1,  9,  9, 4,  24, 1'b1, 1'b0};

      ia.start = 1'b0; ia.in_valid = 1'b0; ia.data_in = '0; ia.weight_in = '0;
      ib.start = 1'b0; ib.in_valid = 1'b0; ib.data_in = '0; ib.weight_in = '0;
      ic.start = 1'b0; ic.in_valid = 1'b0; ic.data_in = '0; ic.weight_in = '0;

      step();
      step();
      chk("a_rst_ready", ia.in_ready, 0);
      chk("a_rst_counter", ia.counter, 0);
      chk("a_rst_sum", ia.mult_sum_out, 0);
      chk("a_rst_done", ia.done, 0);
      rst_n = 1'b1;
      step();

      // 784 beats of 1*1, in_valid held high
      ia.start = 1'b1;
      step();
      ia.start = 1'b0;
      ia.in_valid = 1'b1; ia.data_in = 17'd1; ia.weight_in = 9'd1;
      repeat (785) step();
      chk("a_done_early", ia.done, 0);
      chk("a_counter_785", ia.counter, 783);
      step();
      chk("a_done_786", ia.done, 1);
      chk("a_counter_786", ia.counter, 784);
      chk("a_sum_786", ia.mult_sum_out, 784);
      ia.in_valid = 1'b0;

      // reset mid-ACCUM at counter=100
      ia.start = 1'b1;
      step();
      ia.start = 1'b0;
      ia.in_valid = 1'b1;
      cyc = 0;
      while (ia.counter != 32'd100 && cyc < 300) begin
         step();
         cyc++;
      end
      chk("a_reach_100", ia.counter, 100);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("a_mid_rst_ready", ia.in_ready, 0);
      chk("a_mid_rst_counter", ia.counter, 0);
      chk("a_mid_rst_sum", ia.mult_sum_out, 0);
      chk("a_mid_rst_done", ia.done, 0);
      step();
      step();
      chk("a_flushed_counter", ia.counter, 0);
      chk("a_flushed_sum", ia.mult_sum_out, 0);
      chk("a_idle_ready", ia.in_ready, 0);
      ia.data_in = 17'd2; ia.weight_in = 9'd3;
      ia.start = 1'b1;
      step();
      ia.start = 1'b0;
      cyc = 0;
      while (!ia.done && cyc < 1000) begin
         step();
         cyc++;
      end
      chk("a_fresh_done", ia.done, 1);
      chk("a_fresh_counter", ia.counter, 784);
      chk("a_fresh_sum", ia.mult_sum_out, 4704);
      ia.in_valid = 1'b0;

      // COUNTER_END=4 table with stalls
      ib.start = 1'b1;
      step();
      ib.start = 1'b0;
      chk("b_start_counter", ib.counter, 0);
      for (int i = 0; i < 10; i++) begin
         ib.in_valid = tv[i].v;
         ib.data_in = 17'(tv[i].d);
         ib.weight_in = 9'(tv[i].w);
         step();
         chk($sformatf("b_vec%0d_counter", i), ib.counter, 64'(tv[i].ec));
         chk($sformatf("b_vec%0d_sum", i), ib.mult_sum_out, 64'(tv[i].es));
         chk($sformatf("b_vec%0d_done", i), ib.done, tv[i].ed);
         chk($sformatf("b_vec%0d_ready", i), ib.in_ready, tv[i].er);
      end

      // start in DONE with a beat presented: beat dropped, state cleared
      chk("b_done_ready", ib.in_ready, 0);
      ib.start = 1'b1; ib.in_valid = 1'b1; ib.data_in = 17'd5; ib.weight_in = 9'd5;
      step();
      ib.start = 1'b0; ib.in_valid = 1'b0;
      chk("b_restart_counter", ib.counter, 0);
      chk("b_restart_sum", ib.mult_sum_out, 0);
      chk("b_restart_done", ib.done, 0);
      chk("b_restart_ready", ib.in_ready, 1);
      step();
      step();
      chk("b_dropped_beat", ib.counter, 0);
      ib.in_valid = 1'b1; ib.data_in = 17'd2; ib.weight_in = 9'd3;
      step();
      ib.in_valid = 1'b0;
      step();
      step();
      chk("b_term1_counter", ib.counter, 1);
      chk("b_term1_sum", ib.mult_sum_out, 6);

      // start pulsed mid-ACCUM is ignored
      ib.in_valid = 1'b1; ib.data_in = 17'd1; ib.weight_in = 9'd1; ib.start = 1'b1;
      step();
      ib.start = 1'b0;
      ib.data_in = 17'd4; ib.weight_in = -9'sd2;
      step();
      ib.data_in = 17'd10; ib.weight_in = 9'd10;
      step();
      ib.in_valid = 1'b0;
      cyc = 0;
      while (!ib.done && cyc < 20) begin
         step();
         cyc++;
      end
      chk("b_ign_done", ib.done, 1);
      chk("b_ign_counter", ib.counter, 4);
      chk("b_ign_sum", ib.mult_sum_out, 99);

      // positive saturation at 2^32-1, then a large negative term
      ic.start = 1'b1;
      step();
      ic.start = 1'b0;
      ic.in_valid = 1'b1; ic.weight_in = 15'h3FFF;
      for (int k = 1; k <= 6; k++) begin
         ic.data_in = (k == 6) ? 17'h10000 : 17'h0FFFF;
         step();
      end
      ic.in_valid = 1'b0;
      chk("c_pos4_counter", ic.counter, 4);
      chk("c_pos4_sum", ic.mult_sum_out, 64'sd4294639620);
      step();
      chk("c_pos_clamp", ic.mult_sum_out, 64'sd4294967295);
      chk("c_pos_clamp_done", ic.done, 0);
      step();
      chk("c_pos_final", ic.mult_sum_out, 64'sd3221291007);
      chk("c_pos_done", ic.done, 1);
      chk("c_pos_counter", ic.counter, 6);

      // negative saturation at -2^32, then a large positive term
      ic.start = 1'b1;
      step();
      ic.start = 1'b0;
      ic.in_valid = 1'b1; ic.weight_in = 15'h3FFF;
      for (int k = 1; k <= 6; k++) begin
         ic.data_in = (k == 6) ? 17'h0FFFF : 17'h10000;
         step();
      end
      ic.in_valid = 1'b0;
      chk("c_neg4_sum", ic.mult_sum_out, -64'sd4294705152);
      step();
      chk("c_neg_clamp", ic.mult_sum_out, -64'sd4294967296);
      step();
      chk("c_neg_final", ic.mult_sum_out, -64'sd3221307391);
      chk("c_neg_done", ic.done, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Streaming multiply-accumulate stage for one neuron. It feeds the activation stage (`ReLu`) directly.
- It accepts a handshaked stream of signed activations and weights and forms the saturating dot product.
- It exposes a running term `counter` and the accumulated sum `mult_sum_out`.
- The activation stage adds bias and applies ReLU once `counter >= COUNTER_END`.
- One instance sits per neuron in each layer; `done` tells the layer controller that this neuron's sum is final.

## Interface
Parameters:
- `BITS`, 8: data width base. Input activations are `BITS+9` bits signed, matching the previous layer's neuron output.
- `COUNTER_END`, 784: number of input terms per dot product; legal range 1..2^20.
- `W_BITS`, 8: weight width base. Weights are `W_BITS+1` bits signed; legal range ≤ 14.

Ports:
- `clk`, in, 1: rising-edge clock; the only clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: single-cycle pulse that begins a new dot product.
- `in_valid`, in, 1: `data_in`/`weight_in` pair is valid this cycle.
- `in_ready`, out, 1: block accepts a pair this cycle.
- `data_in`, in, signed `BITS+9`: activation term.
- `weight_in`, in, signed `W_BITS+1`: weight term.
- `counter`, out, 32: number of terms accumulated into `mult_sum_out` so far.
- `mult_sum_out`, out, signed `BITS+25`: accumulated sum.
- `done`, out, 1: high while the sum is final (`counter == COUNTER_END`).

## Operation
- Beat accepted when `in_valid && in_ready`.
- States and transitions:
  - IDLE: `in_ready=0`, `counter=0`, `mult_sum_out=0`, `done=0`. `start` → ACCUM.
  - ACCUM: `in_ready=1` while `issued < COUNTER_END`. `issued` is the internal accepted-beat count. When the `COUNTER_END`-th beat is accepted → DRAIN.
  - DRAIN: `in_ready=0`. Wait until `counter == COUNTER_END` → DONE.
  - DONE: `done=1`; `counter` and `mult_sum_out` held. `start` clears `counter`, `mult_sum_out` and `issued`, then → ACCUM.
- `start` in ACCUM or DRAIN is ignored.
- `start` clears state in the same edge it is sampled. `in_ready` stays low in the `start` cycle, so a beat presented in that cycle is not accepted.
- Arithmetic:
  - Product is `data_in * weight_in`, full width `BITS+W_BITS+10` signed, sign-extended to `BITS+25`.
  - Accumulation saturates. On positive overflow the sum clamps to 2^(BITS+24)−1; on negative overflow it clamps to −2^(BITS+24).
  - Saturation is sticky only in value: later terms keep adding onto the clamped value.
- `counter` increments by 1 per term added; it never exceeds `COUNTER_END`.
- `in_valid` low stalls: no state change except the pipeline draining.

## Timing
- Two-stage pipeline:
  - Beat accepted at edge t.
  - Product register valid after edge t+1.
  - `mult_sum_out` and `counter` updated at edge t+2.
- Back-to-back beats sustain 1 term/cycle.
- `done` rises in the same cycle `counter` first equals `COUNTER_END`, with the final `mult_sum_out`.
- The activation stage registers `mult_sum_in + b` on the following edge.
- Minimum dot-product latency: `start` at edge s with continuous `in_valid` gives `done` after edge s+`COUNTER_END`+2.
- Reset:
  - `rst_n` low at any edge, including mid-ACCUM or DRAIN, forces IDLE.
  - All outputs reset to 0: `in_ready=0`, `counter=0`, `mult_sum_out=0`, `done=0`.
  - The pipeline valid bit is cleared.
  - In-flight products are discarded.
- `COUNTER_END=1`: ACCUM lasts until one beat is accepted, then DRAIN for 2 cycles.

## Structure
- Shared package `mnist_pkg`:
  - state enum `mac_state_t` {IDLE, ACCUM, DRAIN, DONE}.
  - localparam function for accumulator width (`BITS+25`).
  - saturation limit constants derived from it.
- One sub-module: `sat_add`, a parameterised signed saturating adder (operands and result `BITS+25` bits, combinational).
  - Instantiated once in the accumulate stage.
  - Reusable by the layer-sum logic.

## Test plan
- Reset then `start`, 784 beats of `data_in=1`, `weight_in=1`, `in_valid` held high → `done` after edge s+786, `mult_sum_out=784`, `counter=784`.
- `COUNTER_END=4`; beats (3,−2), (−5,4), (7,7), (−1,−1) with `in_valid` toggling 1,0,1,0 → sum is −6−20+49+1=24, `done` only after the 4th term, `counter` steps 0,1,2,3,4 only on accepted beats.
- `BITS=8`, `W_BITS=14`; repeated (2^16−1)×(2^14−1) products → `mult_sum_out` clamps at 2^32−1. Then a large negative term drops the sum from the clamped value.
- `rst_n` low for 1 cycle mid-ACCUM at `counter=100` → next cycle all outputs 0, state IDLE, `in_ready=0`. A later `start` and full run gives the correct fresh sum.
- In DONE with sum 24, assert `start` with `in_valid=1` → beat not accepted, `counter=0`, `mult_sum_out=0`, `done=0`. Next accepted beat counts as term 1.
- `start` pulsed mid-ACCUM → ignored. Final sum and `counter` match a run without the pulse.
